conv_pe_ctrl: RTL and testbench

- Sequencer for one ConvPE instance (3x3 kernel, dwidth-bit signed data).
- Per layer it streams num_ch input channels through the PE: reads din/win from the input FIFOs, drives the PE read enable and configuration, and counts PE output strobes.
- Raises done when the layer is complete.
- Sits between the input FIFOs, the layer-level scheduler (start/done) and ConvPE.

---
 rtl/conv_pe_ctrl_if.sv | 43 ++++
 rtl/conv_pe_ctrl.sv | 137 +++++++++++++
 tb/tb_conv_pe_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_pe_ctrl_if.sv
// conv_pe_ctrl_if: bundles the scheduler, input-FIFO and ConvPE signals of
// one conv_pe_ctrl instance.
//   master : environment side (scheduler, FIFOs and PE drive the inputs)
//   slave  : conv_pe_ctrl side
// Signals:
//   start, featmap_size, num_ch           scheduler -> ctrl
//   busy, done, err, ch_idx               ctrl -> scheduler
//   din_empty, win_empty                  FIFOs -> ctrl
//   din_rd_en, win_rd_en                  ctrl -> FIFOs
//   pe_rd_en, pe_featmap_size,
//   pe_convlayer_state                    ctrl -> ConvPE
//   pe_dout_start                         ConvPE -> ctrl
interface conv_pe_ctrl_if #(
   parameter int unsigned CH_W = 6
);
   logic            start;
   logic [4:0]      featmap_size;
   logic [CH_W-1:0] num_ch;
   logic            din_empty;
   logic            win_empty;
   logic            din_rd_en;
   logic            win_rd_en;
   logic            pe_rd_en;
   logic [4:0]      pe_featmap_size;
   logic            pe_convlayer_state;
   logic            pe_dout_start;
   logic            busy;
   logic            done;
   logic            err;
   logic [CH_W-1:0] ch_idx;

   modport master (
      output start, featmap_size, num_ch, din_empty, win_empty, pe_dout_start,
      input  din_rd_en, win_rd_en, pe_rd_en, pe_featmap_size,
             pe_convlayer_state, busy, done, err, ch_idx
   );

   modport slave (
      input  start, featmap_size, num_ch, din_empty, win_empty, pe_dout_start,
      output din_rd_en, win_rd_en, pe_rd_en, pe_featmap_size,
             pe_convlayer_state, busy, done, err, ch_idx
   );
endinterface

// File: rtl/conv_pe_ctrl.sv
// conv_pe_ctrl: sequencer for one ConvPE (3x3 kernel). For each layer it
// streams num_ch channel passes of N*N din beats (the first KW beats also pop
// a weight), waits for (N-2)^2 PE output strobes per pass, inserts a 2-cycle
// gap between passes and pulses done when the last pass completes.
// Ports:
//   clk    rising-edge system clock
//   rst_n  asynchronous active-low reset
//   bus    conv_pe_ctrl_if.slave (scheduler, FIFO and ConvPE signals)
module conv_pe_ctrl #(
   parameter int unsigned KW   = 9,
   parameter int unsigned CH_W = 6
) (
   input  logic          clk,
   input  logic          rst_n,
   conv_pe_ctrl_if.slave bus
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_STREAM = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_GAP    = 3'd3;
   localparam logic [2:0] S_FINISH = 3'd4;

   localparam logic [9:0] KW_W = 10'(KW);

   logic [2:0]      state;
   logic [9:0]      pix_cnt;
   logic [9:0]      out_cnt;
   logic [9:0]      nn_last;   // N*N-1, index of the final read of a pass
   logic [9:0]      out_tgt;   // (N-2)^2 strobes per pass
   logic [CH_W-1:0] c_last;    // max(num_ch,1)-1
   logic [CH_W-1:0] ch_idx_q;
   logic [4:0]      fm_q;
   logic            gap_q;
   logic            err_q;

   logic            in_pass;
   logic            rd;
   logic            cnt_en;
   logic            last_rd;
   logic            pass_done;
   logic [9:0]      out_cnt_nxt;
   logic [9:0]      fm_ext;
   logic [9:0]      fm_m2;

   always_comb begin
      in_pass     = (state == S_STREAM) || (state == S_WAIT);
      // Weights must accompany data only for the first KW beats.
      rd          = (state == S_STREAM) && !bus.din_empty &&
                    ((pix_cnt >= KW_W) || !bus.win_empty);
      // Saturating strobe count: extras beyond the target are dropped.
      cnt_en      = in_pass && bus.pe_dout_start && (out_cnt != out_tgt);
      out_cnt_nxt = out_cnt + {9'd0, cnt_en};
      last_rd     = rd && (pix_cnt == nn_last);
      // Includes this cycle's strobe so the exit follows the final strobe
      // directly; also true on the entry cycle if the target was already met.
      pass_done   = (state == S_WAIT) && (out_cnt_nxt == out_tgt);
      fm_ext      = {5'd0, bus.featmap_size};
      fm_m2       = fm_ext - 10'd2;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         pix_cnt  <= '0;
         out_cnt  <= '0;
         nn_last  <= '0;
         out_tgt  <= '0;
         c_last   <= '0;
         ch_idx_q <= '0;
         fm_q     <= '0;
         gap_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  if (bus.featmap_size < 5'd3) begin
                     err_q <= 1'b1;
                  end else begin
                     fm_q     <= bus.featmap_size;
                     nn_last  <= fm_ext * fm_ext - 10'd1;
                     out_tgt  <= fm_m2 * fm_m2;
                     c_last   <= (bus.num_ch == '0) ? '0
                                 : CH_W'(bus.num_ch) - CH_W'(1);
                     pix_cnt  <= '0;
                     out_cnt  <= '0;
                     ch_idx_q <= '0;
                     state    <= S_STREAM;
                  end
               end
            end
            S_STREAM: begin
               if (rd) pix_cnt <= pix_cnt + 10'd1;
               out_cnt <= out_cnt_nxt;
               if (last_rd) state <= S_WAIT;
            end
            S_WAIT: begin
               out_cnt <= out_cnt_nxt;
               if (pass_done) begin
                  if (ch_idx_q == c_last) begin
                     state <= S_FINISH;
                  end else begin
                     state    <= S_GAP;
                     gap_q    <= 1'b0;
                     ch_idx_q <= ch_idx_q + CH_W'(1);
                     pix_cnt  <= '0;
                     out_cnt  <= '0;
                  end
               end
            end
            S_GAP: begin
               if (gap_q) state <= S_STREAM;
               else       gap_q <= 1'b1;
            end
            S_FINISH: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.din_rd_en          = rd;
   assign bus.pe_rd_en           = rd;
   assign bus.win_rd_en          = rd && (pix_cnt < KW_W);
   assign bus.busy               = in_pass || (state == S_GAP);
   assign bus.pe_convlayer_state = in_pass || (state == S_GAP);
   assign bus.done               = (state == S_FINISH);
   assign bus.err                = err_q;
   assign bus.ch_idx             = ch_idx_q;
   assign bus.pe_featmap_size    = fm_q;

endmodule

// File: tb/tb_conv_pe_ctrl.sv
// tb_conv_pe_ctrl: self-checking bench for conv_pe_ctrl. A table of layer
// configurations is run with full FIFOs and checked on aggregate counts,
// hand-written sequences cover stalls, reset and ignored starts, and random
// layers are checked cycle by cycle against an event-timeline model.
module tb_conv_pe_ctrl;
   localparam int unsigned CH_W = 6;
   localparam int unsigned KW   = 9;
   localparam int          MAXC = 3000;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   conv_pe_ctrl_if #(.CH_W(CH_W)) bus();
   conv_pe_ctrl #(.KW(KW), .CH_W(CH_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_cmp = 0;
   int n_bad = 0;

   // random-layer stimulus and expected timeline
   bit de_a[MAXC];
   bit we_a[MAXC];
   bit st_a[MAXC];
   bit sp_a[MAXC];
   bit e_rd[MAXC];
   bit e_wr[MAXC];
   bit e_busy[MAXC];
   bit e_done[MAXC];
   int e_ch[MAXC];
   int prev_ch;
   int prev_fm;

   typedef struct {
      int fm; int nch; int din; int win; int busy; int done; int err; int maxch;
   } vec_t;
   vec_t tbl[8];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: actual 'h%0h required 'h%0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.start         = 1'b0;
      bus.din_empty     = 1'b1;
      bus.win_empty     = 1'b1;
      bus.pe_dout_start = 1'b0;
   endtask

   function automatic int pack_out();
      return 32'({bus.pe_featmap_size, bus.ch_idx, bus.pe_rd_en, bus.din_rd_en,
                  bus.win_rd_en, bus.busy, bus.pe_convlayer_state, bus.done, bus.err});
   endfunction

   task automatic run_layer(input int fm, input int nch, input int poke,
                            output int din, output int win, output int busy_c,
                            output int done_c, output int err_c, output int max_ch,
                            output int fm_last);
      int  post;
      bit  seen_busy;
      din = 0; win = 0; busy_c = 0; done_c = 0; err_c = 0; max_ch = 0;
      post = 0; seen_busy = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         next_cycle();
         bus.din_empty     = 1'b0;
         bus.win_empty     = 1'b0;
         bus.pe_dout_start = 1'b1;
         if (c == 0) begin
            bus.start = 1'b1; bus.featmap_size = 5'(fm); bus.num_ch = 6'(nch);
         end else if (poke != 0 && c == poke) begin
            bus.start = 1'b1; bus.featmap_size = 5'd7; bus.num_ch = 6'd3;
         end else begin
            bus.start = 1'b0;
         end
         sample();
         din   += int'(bus.din_rd_en);
         win   += int'(bus.win_rd_en);
         err_c += int'(bus.err);
         if (bus.busy) begin
            busy_c++;
            seen_busy = 1'b1;
            if (int'(bus.ch_idx) > max_ch) max_ch = int'(bus.ch_idx);
         end
         if (done_c > 0) post++;
         done_c += int'(bus.done);
         if (post >= 3) break;
         if (c >= 8 && !seen_busy) break;
      end
      fm_last = int'(bus.pe_featmap_size);
      idle_inputs();
   endtask

   task automatic finish_layer(input string name);
      bit seen = 1'b0;
      for (int k = 0; k < 200 && !seen; k++) begin
         next_cycle();
         bus.start = 1'b0; bus.din_empty = 1'b0; bus.win_empty = 1'b0;
         bus.pe_dout_start = 1'b1;
         sample();
         if (bus.done) seen = 1'b1;
      end
      check({name, "_done"}, int'(seen), 1);
      idle_inputs();
      repeat (2) next_cycle();
   endtask

   task automatic do_reset();
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      prev_ch = 0;
      prev_fm = 0;
   endtask

   task automatic run_random(input int idx);
      int n, nch, c, tgt, s, beat, t, e, cnt, f, exp;
      bit ok;
      n   = int'($urandom_range(3, 8));
      nch = int'($urandom_range(0, 3));
      c   = (nch == 0) ? 1 : nch;
      tgt = (n - 2) * (n - 2);
      for (int i = 0; i < MAXC; i++) begin
         de_a[i] = ($urandom_range(0, 3) == 0);
         we_a[i] = ($urandom_range(0, 3) == 0);
         st_a[i] = ($urandom_range(0, 2) == 0);
         sp_a[i] = 1'b0;
         e_rd[i] = 1'b0; e_wr[i] = 1'b0; e_busy[i] = 1'b0; e_done[i] = 1'b0;
         e_ch[i] = prev_ch;
      end
      // Build the expected event timeline pass by pass: the read cycles, the
      // cycle where counted strobes reach the target, then gap or finish.
      s = 1; ok = 1'b1; f = 0;
      for (int p = 0; p < c && ok; p++) begin
         beat = 0; t = s; cnt = 0;
         while (beat < n * n && t < MAXC - 4) begin
            e_busy[t] = 1'b1; e_ch[t] = p;
            if (!de_a[t] && (beat >= int'(KW) || !we_a[t])) begin
               e_rd[t] = 1'b1;
               e_wr[t] = (beat < int'(KW));
               beat++;
            end
            cnt += int'(st_a[t]);
            t++;
         end
         if (beat < n * n) ok = 1'b0;
         e = t;
         while (ok && e < MAXC - 4) begin
            cnt += int'(st_a[e]);
            e_busy[e] = 1'b1; e_ch[e] = p;
            if (cnt >= tgt) break;
            e++;
         end
         if (e >= MAXC - 4) ok = 1'b0;
         if (ok) begin
            if (p < c - 1) begin
               e_busy[e+1] = 1'b1; e_busy[e+2] = 1'b1;
               e_ch[e+1] = p + 1;  e_ch[e+2] = p + 1;
               s = e + 3;
            end else begin
               f = e + 1;
               e_done[f] = 1'b1;
               e_ch[f] = p; e_ch[f+1] = p;
            end
         end
      end
      if (!ok) begin
         n_cmp++; n_bad++;
         $display("FAIL rnd%0d_bound: layer did not complete within %0d cycles", idx, MAXC);
         return;
      end
      for (int i = 1; i <= f; i++) sp_a[i] = ($urandom_range(0, 11) == 0);
      for (int i = 0; i <= f + 1; i++) begin
         next_cycle();
         if (i == 0) begin
            bus.start = 1'b1; bus.featmap_size = 5'(n); bus.num_ch = 6'(nch);
         end else begin
            bus.start = sp_a[i];
            if (sp_a[i]) begin
               bus.featmap_size = 5'($urandom_range(0, 31));
               bus.num_ch       = 6'($urandom_range(0, 63));
            end
         end
         bus.din_empty     = de_a[i];
         bus.win_empty     = we_a[i];
         bus.pe_dout_start = st_a[i];
         sample();
         exp = 32'({5'((i == 0) ? prev_fm : n), 6'(e_ch[i]), e_rd[i], e_rd[i], e_wr[i],
                    e_busy[i], e_busy[i], e_done[i], 1'b0});
         check($sformatf("rnd%0d_c%0d", idx, i), pack_out(), exp);
      end
      prev_ch = c - 1;
      prev_fm = n;
      idle_inputs();
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int din, win, busy_c, done_c, err_c, max_ch, fm_last;
      int beat, cyc, bad, dpop, wpop, exp_i;
      bit f3, f12, f5, f15, de, we, exp_rd;

      tbl[0] = '{5,  1, 25,  9,  26, 1, 0, 0};
      tbl[1] = '{5,  2, 50,  18, 54, 1, 0, 1};
      tbl[2] = '{2,  1, 0,   0,  0,  0, 1, 0};
      tbl[3] = '{3,  1, 9,   9,  10, 1, 0, 0};
      tbl[4] = '{3,  0, 9,   9,  10, 1, 0, 0};
      tbl[5] = '{4,  3, 48,  27, 55, 1, 0, 2};
      tbl[6] = '{28, 1, 784, 9,  785, 1, 0, 0};
      tbl[7] = '{0,  2, 0,   0,  0,  0, 1, 0};

      rst_n = 1'b0;
      idle_inputs();
      bus.featmap_size = '0;
      bus.num_ch       = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", pack_out(), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Table: full FIFOs, PE strobing every cycle.
      for (int i = 0; i < 8; i++) begin
         run_layer(tbl[i].fm, tbl[i].nch, 0, din, win, busy_c, done_c, err_c, max_ch, fm_last);
         check($sformatf("tbl%0d_din_pops", i), din, tbl[i].din);
         check($sformatf("tbl%0d_win_pops", i), win, tbl[i].win);
         check($sformatf("tbl%0d_busy_cycles", i), busy_c, tbl[i].busy);
         check($sformatf("tbl%0d_done", i), done_c, tbl[i].done);
         check($sformatf("tbl%0d_err", i), err_c, tbl[i].err);
         check($sformatf("tbl%0d_max_ch", i), max_ch, tbl[i].maxch);
      end

      // N=5, strobes only after the reads: done follows the 9th strobe.
      next_cycle();
      bus.start = 1'b1; bus.featmap_size = 5'd5; bus.num_ch = 6'd1;
      bus.din_empty = 1'b0; bus.win_empty = 1'b0; bus.pe_dout_start = 1'b0;
      sample();
      bad = 0;
      for (int i = 0; i < 25; i++) begin
         next_cycle();
         bus.start = 1'b0;
         sample();
         if (!bus.pe_rd_en || !bus.din_rd_en || (bus.win_rd_en != (i < 9))) bad++;
      end
      check("tp1_stream_25", bad, 0);
      next_cycle();
      sample();
      check("tp1_wait_no_rd", int'(bus.pe_rd_en), 0);
      check("tp1_wait_busy", int'(bus.busy), 1);
      bad = 0;
      for (int k = 0; k < 9; k++) begin
         next_cycle();
         bus.pe_dout_start = 1'b1;
         sample();
         if (bus.done || !bus.busy) bad++;
      end
      check("tp1_no_early_done", bad, 0);
      next_cycle();
      bus.pe_dout_start = 1'b0;
      sample();
      check("tp1_done", int'(bus.done), 1);
      check("tp1_busy_low", int'(bus.busy), 0);
      next_cycle();
      sample();
      check("tp1_done_pulse", int'(bus.done), 0);
      idle_inputs();

      // N=5 with FIFO underflows at data beats 3,12 and weight beats 5,15.
      next_cycle();
      bus.start = 1'b1; bus.featmap_size = 5'd5; bus.num_ch = 6'd1;
      bus.din_empty = 1'b0; bus.win_empty = 1'b0; bus.pe_dout_start = 1'b1;
      sample();
      beat = 0; cyc = 0; bad = 0; dpop = 0; wpop = 0;
      f3 = 1'b0; f12 = 1'b0; f5 = 1'b0; f15 = 1'b0;
      while (beat < 25 && cyc < 60) begin
         next_cycle();
         bus.start = 1'b0;
         de = (beat == 3 && !f3) || (beat == 12 && !f12);
         we = (beat == 5 && !f5) || (beat == 15 && !f15);
         if (de && beat == 3)  f3  = 1'b1;
         if (de && beat == 12) f12 = 1'b1;
         if (we && beat == 5)  f5  = 1'b1;
         if (we && beat == 15) f15 = 1'b1;
         bus.din_empty = de;
         bus.win_empty = we;
         sample();
         exp_rd = !de && (beat >= 9 || !we);
         if (bus.pe_rd_en != exp_rd || bus.din_rd_en != exp_rd ||
             bus.win_rd_en != (exp_rd && beat < 9)) bad++;
         dpop += int'(bus.din_rd_en);
         wpop += int'(bus.win_rd_en);
         if (exp_rd) beat++;
         cyc++;
      end
      check("stall_rd_pattern", bad, 0);
      check("stall_din_pops", dpop, 25);
      check("stall_win_pops", wpop, 9);
      check("stall_cycles", cyc, 28);
      finish_layer("stall");

      // Asynchronous reset in the middle of a pass, then a clean restart.
      next_cycle();
      bus.start = 1'b1; bus.featmap_size = 5'd5; bus.num_ch = 6'd2;
      bus.din_empty = 1'b0; bus.win_empty = 1'b0; bus.pe_dout_start = 1'b0;
      sample();
      for (int i = 0; i < 10; i++) begin
         next_cycle();
         bus.start = 1'b0;
         sample();
      end
      next_cycle();
      check("rst_pre_rd", int'(bus.pe_rd_en), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async_outputs", pack_out(), 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_layer(5, 1, 0, din, win, busy_c, done_c, err_c, max_ch, fm_last);
      check("rst_restart_din", din, 25);
      check("rst_restart_win", win, 9);
      check("rst_restart_done", done_c, 1);

      // start with N=7 mid-stream must be ignored.
      run_layer(5, 1, 11, din, win, busy_c, done_c, err_c, max_ch, fm_last);
      check("restart_ign_din", din, 25);
      check("restart_ign_win", win, 9);
      check("restart_ign_busy", busy_c, 26);
      check("restart_ign_done", done_c, 1);
      check("restart_ign_fm", fm_last, 5);

      // Random layers against the timeline model.
      do_reset();
      for (int r = 0; r < 8; r++) run_random(r);

      exp_i = 0;
      repeat (2) next_cycle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + exp_i);
      $finish;
   end
endmodule
